// File: rtl/mdu_pkg.sv
// Shared constants, state encoding and sign helpers for the multi-cycle
// multiply/divide sequencer.
package mdu_pkg;

   localparam int         WIDTH  = 32;
   localparam logic [4:0] MUL_OP = 5'h1E;
   localparam logic [4:0] DIV_OP = 5'h1F;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   function automatic logic [2*WIDTH-1:0] cond_neg64(input logic [2*WIDTH-1:0] v,
                                                     input logic               neg);
      return neg ? (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1} : v;
   endfunction

   // Also yields the magnitude of a signed word; the most negative value maps to itself.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
      return neg ? (~v) + {{(WIDTH-1){1'b0}}, 1'b1} : v;
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// The accumulator is {HI half, LO half}; the divider's quotient bit enters at bit 0.
module mdu_step
   import mdu_pkg::*;
(
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   mag,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;

   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag & {WIDTH{acc[0]}}};
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      // The trial difference always fits in WIDTH bits whenever it is kept.
      rem_sub = rem_sh[WIDTH-1:0] - mag;
      q_bit   = 1'b0;
      if (is_div) begin
         q_bit    = (rem_sh >= {1'b0, mag});
         acc_next = {q_bit ? rem_sub : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle signed multiply/divide sequencer owning the HI/LO registers,
// with a start/busy/done handshake for the control unit.
module mdu_sequencer
   import mdu_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [4:0]       FS,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] T,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] Y_HI,
   output logic [WIDTH-1:0] Y_LO,
   output logic             N,
   output logic             Z
);

   state_t             state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               s_sign_q, s_sign_d;
   logic               t_sign_q, t_sign_d;
   logic [WIDTH-1:0]   mag_s_q, mag_s_d;
   logic [WIDTH-1:0]   mag_t_q, mag_t_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               n_q, n_d;
   logic               z_q, z_d;
   logic               div0_q, div0_d;

   logic               accept;
   logic [2*WIDTH-1:0] step_acc;
   logic               step_q_bit;
   logic [2*WIDTH-1:0] product;

   mdu_step u_step (
      .is_div   (is_div_q),
      .acc      (acc_q),
      .mag      (mag_t_q),
      .acc_next (step_acc),
      .q_bit    (step_q_bit)
   );

   always_comb begin
      // NOTE: every _d starts at its held value so no branch below can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      s_sign_d = s_sign_q;
      t_sign_d = t_sign_q;
      mag_s_d  = mag_s_q;
      mag_t_d  = mag_t_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      n_d      = n_q;
      z_d      = z_q;
      div0_d   = div0_q;

      accept  = start && (FS == MUL_OP || FS == DIV_OP);
      product = cond_neg64(acc_q, s_sign_q ^ t_sign_q);

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               is_div_d = (FS == DIV_OP);
               s_sign_d = S[WIDTH-1];
               t_sign_d = T[WIDTH-1];
               mag_s_d  = cond_neg(S, S[WIDTH-1]);
               mag_t_d  = cond_neg(T, T[WIDTH-1]);
               acc_d    = {{WIDTH{1'b0}}, mag_s_d};
               cnt_d    = '0;
               state_d  = (FS == DIV_OP && T == '0) ? FIX : RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q_bit};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = FIX;
            end
         end
         FIX: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
               div0_d  = 1'b0;
               if (!is_div_q) begin
                  {hi_d, lo_d} = product;
               end else if (mag_t_q == '0) begin
                  hi_d   = cond_neg(mag_s_q, s_sign_q);
                  lo_d   = '1;
                  div0_d = 1'b1;
               end else begin
                  // Quotient sign from both operands, remainder follows the dividend.
                  lo_d = cond_neg(acc_q[WIDTH-1:0], s_sign_q ^ t_sign_q);
                  hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], s_sign_q);
               end
               n_d = is_div_q ? lo_d[WIDTH-1] : hi_d[WIDTH-1];
               z_d = ({hi_d, lo_d} == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         s_sign_q <= 1'b0;
         t_sign_q <= 1'b0;
         mag_s_q  <= '0;
         mag_t_q  <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         n_q      <= 1'b0;
         z_q      <= 1'b1;
         div0_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         s_sign_q <= s_sign_d;
         t_sign_q <= t_sign_d;
         mag_s_q  <= mag_s_d;
         mag_t_q  <= mag_t_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         n_q      <= n_d;
         z_q      <= z_d;
         div0_q   <= div0_d;
      end
   end

   assign busy = (state_q == RUN) || (state_q == FIX);
   assign done = (state_q == DONE);
   assign div0 = div0_q;
   assign Y_HI = hi_q;
   assign Y_LO = lo_q;
   assign N    = n_q;
   assign Z    = z_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: the driver pushes reference results computed
// with plain signed arithmetic, and a monitor pops and compares on every done pulse.
module tb_mdu_sequencer;
   import mdu_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        n;
      logic        z;
      logic        dz;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [4:0]  FS;
   logic [31:0] S;
   logic [31:0] T;
   logic        flush;
   logic        busy;
   logic        done;
   logic        div0;
   logic [31:0] Y_HI;
   logic [31:0] Y_LO;
   logic        N;
   logic        Z;

   int          n_vec  = 0;
   int          n_err  = 0;
   int          cyc    = 0;
   exp_t        sb[$];
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   mdu_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .FS      (FS),
      .S       (S),
      .T       (T),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .div0    (div0),
      .Y_HI    (Y_HI),
      .Y_LO    (Y_LO),
      .N       (N),
      .Z       (Z)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
      exp_t        e;
      longint      ss;
      longint      tt;
      longint      q;
      longint      r;
      logic [63:0] p;
      logic [63:0] qv;
      logic [63:0] rv;
      ss   = $signed(s);
      tt   = $signed(t);
      e.dz = 1'b0;
      if (fs == MUL_OP) begin
         p    = ss * tt;
         e.hi = p[63:32];
         e.lo = p[31:0];
         e.n  = e.hi[31];
      end else begin
         if (t == 32'd0) begin
            e.hi = s;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
         end else begin
            q    = ss / tt;
            r    = ss % tt;
            qv   = q;
            rv   = r;
            e.lo = qv[31:0];
            e.hi = rv[31:0];
         end
         e.n = e.lo[31];
      end
      e.z   = ({e.hi, e.lo} == 64'd0);
      e.due = 0;
      return e;
   endfunction

   // Called right after a rising edge; the request is accepted on the next edge.
   task automatic issue(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                        input bit expect_result);
      exp_t e;
      start = 1'b1;
      FS    = fs;
      S     = s;
      T     = t;
      if (expect_result) begin
         e     = model(fs, s, t);
         e.due = cyc + 1 + ((fs == DIV_OP && t == 32'd0) ? 1 : 33);
         sb.push_back(e);
         prev_hi = e.hi;
         prev_lo = e.lo;
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         seen = done;
      end
      if (!seen) check("done_timeout", {63'd0, done}, 64'd1);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'h0 - 32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compare every done pulse with the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (done) begin
            if (sb.size() == 0) begin
               check("done_unexpected", {63'd0, done}, 64'd0);
            end else begin
               e = sb.pop_front();
               check("latency", 64'(cyc), 64'(e.due));
               check("Y_HI", {32'd0, Y_HI}, {32'd0, e.hi});
               check("Y_LO", {32'd0, Y_LO}, {32'd0, e.lo});
               check("N", {63'd0, N}, {63'd0, e.n});
               check("Z", {63'd0, Z}, {63'd0, e.z});
               check("div0", {63'd0, div0}, {63'd0, e.dz});
            end
         end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            check("done_at_due", {63'd0, done}, 64'd1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [4:0] fs;
      reset_n = 1'b0;
      start   = 1'b0;
      flush   = 1'b0;
      FS      = 5'd0;
      S       = '0;
      T       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_div0", {63'd0, div0}, 64'd0);
      check("rst_hilo", {Y_HI, Y_LO}, 64'd0);
      check("rst_N", {63'd0, N}, 64'd0);
      check("rst_Z", {63'd0, Z}, 64'd1);
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue(MUL_OP, 32'd7, 32'hFFFF_FFFD, 1'b1);
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      wait_done();
      @(posedge clk); #1;
      issue(DIV_OP, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done();
      issue(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done();
      @(posedge clk); #1;
      issue(DIV_OP, 32'h1234_5678, 32'd0, 1'b1);
      wait_done();
      @(posedge clk); #1;
      issue(MUL_OP, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_done();
      issue(MUL_OP, 32'd0, 32'd5, 1'b1);
      wait_done();
      @(posedge clk); #1;

      // Unsupported function code must leave the sequencer idle.
      start = 1'b1;
      FS    = 5'h05;
      @(posedge clk); #1;
      start = 1'b0;
      check("bad_fs_ignored", {63'd0, busy}, 64'd0);

      // Flush on the tenth RUN cycle, with a competing start in the same cycle.
      issue(DIV_OP, $urandom, 32'($urandom_range(1, 1000)), 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      start = 1'b1;
      FS    = MUL_OP;
      @(posedge clk); #1;
      flush = 1'b0;
      start = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      check("flush_hold_hi", {32'd0, Y_HI}, {32'd0, prev_hi});
      check("flush_hold_lo", {32'd0, Y_LO}, {32'd0, prev_lo});
      issue(MUL_OP, rand_operand(), rand_operand(), 1'b1);
      wait_done();
      @(posedge clk); #1;

      // start pulsed while busy is ignored.
      issue(MUL_OP, rand_operand(), rand_operand(), 1'b1);
      repeat (5) begin @(posedge clk); #1; end
      start = 1'b1;
      FS    = DIV_OP;
      S     = $urandom;
      T     = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
         fs = ($urandom_range(0, 1) == 1) ? DIV_OP : MUL_OP;
         issue(fs, rand_operand(), rand_operand(), 1'b1);
         wait_done();
      end
      @(posedge clk); #1;

      // Asynchronous reset in the middle of RUN.
      issue(MUL_OP, 32'h0001_2345, 32'h0000_0777, 1'b1);
      repeat (5) begin @(posedge clk); #1; end
      #2;
      reset_n = 1'b0;
      sb.delete();
      prev_hi = '0;
      prev_lo = '0;
      #1;
      check("async_rst_busy", {63'd0, busy}, 64'd0);
      check("async_rst_hilo", {Y_HI, Y_LO}, 64'd0);
      check("async_rst_Z", {63'd0, Z}, 64'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      issue(DIV_OP, 32'd100, 32'hFFFF_FFF9, 1'b1);
      wait_done();
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer for the integer datapath. It replaces the single-cycle combinational MUL/DIV path with a 32-iteration signed shift-add multiplier and restoring divider. It owns the architectural HI/LO registers and gives the control unit a start/busy/done handshake so the pipeline can stall on MFHI/MFLO.

## Interface
- WIDTH, 32, operand width; the design is only required to work at 32.
- MUL_OP, 5'h1E, FS code for signed multiply.
- DIV_OP, 5'h1F, FS code for signed divide.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE or DONE.
- FS  in  5  function select; only MUL_OP or DIV_OP are accepted.
- S  in  32  operand / dividend.
- T  in  32  operand / divisor.
- flush  in  1  synchronous cancel of an in-flight operation.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse; HI/LO are valid when it is high.
- div0  out  1  divide by zero occurred; registered with HI/LO.
- Y_HI  out  32  HI register: product upper half, or remainder.
- Y_LO  out  32  LO register: product lower half, or quotient.
- N, Z  out  1  flags, registered with HI/LO.
  - N: HI[31] for MUL, LO[31] for DIV.
  - Z: {HI,LO} == 0.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Accept condition: start=1, FS∈{MUL_OP, DIV_OP}, state is IDLE or DONE.
  - On accept, latch the operation, the signs sS=S[31] and sT=T[31], and the magnitudes |S| and |T| as 32-bit unsigned values. |0x80000000| = 0x80000000.
  - Clear the 6-bit iteration counter.
  - Other FS values are ignored (no state change).
  - start is ignored while busy.
- RUN, MUL: 32 shift-add steps on a 64-bit accumulator.
- RUN, DIV: 32 restoring steps (shift, trial subtract, set quotient bit).
- RUN exits to FIX when the counter reaches 31.
- DIV with T==0: skip RUN and go straight to FIX.
- FIX (one cycle) applies signs and writes HI/LO, N, Z, div0; the next state is DONE.
  - MUL: negate the 64-bit result if sS^sT.
  - DIV: quotient negative if sS^sT; remainder takes sign sS.
  - Two's-complement wrap: -2^31 / -1 → LO=0x80000000, HI=0.
  - Divide by zero: LO=0xFFFFFFFF, HI=S, div0=1. For every other operation, div0=0.
- DONE: done=1 for one cycle, then back to IDLE unless a new start is accepted in that same cycle.
- flush=1 in RUN or FIX:
  - Next state is IDLE.
  - HI/LO, N, Z, div0 are not written, and no done pulse is produced.
  - flush has no effect in IDLE or DONE.
  - flush and start in the same cycle: flush wins; start is dropped.
- HI/LO hold their value between operations.

## Timing
- Reset: state=IDLE; busy=0, done=0, div0=0; Y_HI=Y_LO=0; N=0, Z=1; counter=0.
- Accept on edge k:
  - busy is high from after edge k.
  - FIX is entered at edge k+32 and DONE at edge k+33.
  - done and the new HI/LO are visible after edge k+33, so latency is 33 cycles.
- Divide by zero, accept on edge k: FIX after edge k, DONE after edge k+1.
- Back-to-back operations: a start accepted in DONE gives its next accept edge with no idle bubble.
- reset_n asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Structure
- Package mdu_pkg holds:
  - WIDTH, MUL_OP, DIV_OP;
  - the state enum {IDLE, RUN, FIX, DONE};
  - a function for 64-bit conditional negation.
- One sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: operation, accumulator, operand magnitude.
  - Outputs: next accumulator and quotient bit.
- The top level holds the FSM, counter, operand registers, and HI/LO/flag registers.

## Test plan
- MUL S=7, T=0xFFFFFFFD (−3) → done 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB, N=1, Z=0.
- DIV S=0xFFFFFFF9 (−7), T=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, div0=0; then DIV S=0x80000000, T=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV S=0x12345678, T=0 → done 2 cycles after accept; LO=0xFFFFFFFF, HI=0x12345678, div0=1.
- MUL 0x80000000 × 0x80000000 → HI=0x40000000, LO=0; back-to-back MUL 0×5 issued in DONE → Z=1 and done exactly 33 cycles later.
- DIV started, flush on the 10th RUN cycle → no done; HI/LO keep their prior values; start on the next cycle is accepted.
- reset_n low during RUN → busy=0, Y_HI=Y_LO=0 immediately; start pulsed while busy → ignored, result unchanged.
